// File: rtl/bit_serial_sub_pkg.sv
// bit_serial_sub_pkg
// Shared constants for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package bit_serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_sub_if.sv
// bit_serial_sub_if
// Request/result bundle of the bit-serial subtractor.
//   start, a, b : request side (driven by the master)
//   busy, done  : status (driven by the subtractor)
//   diff, borr  : registered result (driven by the subtractor)
// Modports: master (requester), slave (subtractor).
interface bit_serial_sub_if
  import bit_serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borr;

  modport master (
    output start, a, b,
    input  busy, done, diff, borr
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borr
  );

endinterface

// File: rtl/full_half_sub.sv
// full_half_sub
// One-bit full subtractor: computes a - b - c.
//   a    : minuend bit
//   b    : subtrahend bit
//   c    : borrow in
//   diff : difference bit
//   borr : borrow out
module full_half_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borr
);

  assign diff = a ^ b ^ c;
  // A borrow is needed when the minuend bit is 0 and something is taken
  // from it, or when both b and c must be taken from a 1.
  assign borr = (~a & (b | c)) | (b & c);

endmodule

// File: rtl/bit_serial_sub.sv
// bit_serial_sub
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, borr = (a < b).
// One bit is processed per clock, LSB first, through a single full
// subtractor. A request is accepted in IDLE, WIDTH SHIFT cycles follow and
// a one-cycle done pulse presents the result.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : bit_serial_sub_if slave (start, a, b in; busy, done, diff, borr out)
module bit_serial_sub
  import bit_serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_sub_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   a_sr_r;
  logic [WIDTH-1:0]   b_sr_r;
  logic [WIDTH-1:0]   d_sr_r;
  logic               borrow_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borr_r;
  logic               busy_r;
  logic               done_r;
  logic               accept_s;
  logic               last_s;
  logic               fs_diff_s;
  logic               fs_borr_s;
  logic [WIDTH-1:0]   d_next_s;

  full_half_sub u_fs (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .c    (borrow_r),
    .diff (fs_diff_s),
    .borr (fs_borr_s)
  );

  // New difference bit enters at the MSB so the LSB-first stream lands aligned.
  assign d_next_s = {fs_diff_s, d_sr_r[WIDTH-1:1]};

  // Next-state decode plus accept / last-bit strobes.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s  = SHIFT;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_BIT) begin
          state_s = DONE;
          last_s  = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      d_sr_r   <= '0;
      borrow_r <= 1'b0;
      diff_r   <= '0;
      borr_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      // Status flags are registered from the next state so they line up
      // exactly with the state they describe.
      busy_r  <= (state_s == SHIFT);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        a_sr_r   <= bus.a;
        b_sr_r   <= bus.b;
        d_sr_r   <= '0;
        cnt_r    <= '0;
        borrow_r <= 1'b0;
        diff_r   <= '0;
        borr_r   <= 1'b0;
      end else if (state_r == SHIFT) begin
        a_sr_r   <= a_sr_r >> 1;
        b_sr_r   <= b_sr_r >> 1;
        d_sr_r   <= d_next_s;
        borrow_r <= fs_borr_s;
        cnt_r    <= cnt_r + CNT_W'(1);
        // Result is published only once complete, never as a partial value.
        if (last_s) begin
          diff_r <= d_next_s;
          borr_r <= fs_borr_s;
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.borr = borr_r;

endmodule

// File: tb/tb_bit_serial_sub.sv
// tb_bit_serial_sub
// Self-checking bench for bit_serial_sub (WIDTH=8): a transaction-level
// reference model compared every cycle, plus directed cases with literal
// expected values.
module tb_bit_serial_sub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bit_serial_sub_if #(.WIDTH(W)) bus ();

  bit_serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is taken whenever nothing is in flight; the
  // result appears W cycles later for one cycle, outputs clear on accept.
  logic         m_busy, m_done, m_borr, m_bor_p;
  logic [W-1:0] m_diff, m_res;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_borr <= 1'b0; m_bor_p <= 1'b0;
      m_diff <= '0; m_res <= '0; m_left <= 0;
    end else if (!m_busy && !m_done && bus.start) begin
      m_res   <= bus.a - bus.b;
      m_bor_p <= (bus.a < bus.b);
      m_diff  <= '0;
      m_borr  <= 1'b0;
      m_busy  <= 1'b1;
      m_left  <= W;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_diff <= m_res;
        m_borr <= m_bor_p;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("diff", bus.diff, m_diff);
      chk("borr", bus.borr, m_borr);
      chk("busy_done_excl", bus.busy & bus.done, 1'b0);
    end
  end

  // One transaction with literal expectations, latency and busy-length checks.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ed, input logic eb,
                        input bit now, input string name);
    int lat;
    int busy_n;
    bit seen;
    lat = 0; busy_n = 0; seen = 1'b0;
    if (!now) begin
      @(negedge clk);
    end
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    chk({name, "_seen"}, seen, 1'b1);
    if (seen) begin
      chk({name, "_lat"}, lat, 9);
      chk({name, "_busy_len"}, busy_n, 8);
      chk({name, "_diff"}, bus.diff, ed);
      chk({name, "_borr"}, bus.borr, eb);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  prev_done;
    int  n_done;
    logic [W-1:0] ra, rb;

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_diff", bus.diff, 8'h00);
    chk("rst_borr", bus.borr, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, "op_5a_3c");
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "op_00_01");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "op_ff_ff");
    run_op(8'h01, 8'hFF, 8'h02, 1'b1, 1'b0, "op_01_ff");
    run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, "op_ff_00");

    // Start held high; operands scrambled while shifting must not matter.
    prev_done = -1; n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        chk("hold_diff", bus.diff, 8'h0F);
        chk("hold_borr", bus.borr, 1'b0);
        if (prev_done >= 0) chk("hold_period", c - prev_done, 10);
        prev_done = c;
        n_done++;
      end
      if (m_busy) begin
        bus.a = 8'($urandom); bus.b = 8'($urandom);
      end else begin
        bus.a = 8'h10; bus.b = 8'h01;
      end
    end
    bus.start = 1'b0; bus.a = 8'h10; bus.b = 8'h01;
    chk("hold_n_done", n_done, 4);
    for (int c = 0; c < 20 && (m_busy || m_done); c++) @(negedge clk);
    chk("hold_drained", m_busy | m_done, 1'b0);

    // Reset after the 4th SHIFT edge aborts with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_diff", bus.diff, 8'h00);
    chk("abort_borr", bus.borr, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("abort_hold_done", bus.done, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "post_reset");

    // Random operands against arithmetic expectations.
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      run_op(ra, rb, ra - rb, (ra < rb), 1'b0, "rand");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
